// File: rtl/star_pkg.sv
// Shared constants for the star tracker pixel path: image geometry, field widths
// and requester indices used by the pixel read arbiter and its clients.
package star_pkg;

  localparam int unsigned X_RES         = 60;
  localparam int unsigned Y_RES         = 60;
  localparam int unsigned PIX_THRESHOLD = 0;
  localparam int unsigned COORD_W       = 6;
  localparam int unsigned ADDR_W        = 12;
  localparam int unsigned PIX_W         = 3;

  localparam int unsigned REQ_SCAN = 0;
  localparam int unsigned REQ_TB   = 1;
  localparam int unsigned REQ_LR   = 2;

  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pix_addr_xlate.sv
// Combinational (x, y) to linear RAM address translation with out-of-range detection.
// Out-of-range coordinates map to address 0 so the RAM read port never sees a wild address.
module pix_addr_xlate
  import star_pkg::*;
#(
  parameter int unsigned X_RES = star_pkg::X_RES,
  parameter int unsigned Y_RES = star_pkg::Y_RES
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               oor_o
);

  logic [ADDR_W-1:0] lin_addr;

  always_comb begin
    oor_o    = (32'(x_i) >= X_RES) || (32'(y_i) >= Y_RES);
    lin_addr = ADDR_W'(y_i) * ADDR_W'(X_RES) + ADDR_W'(x_i);
    addr_o   = oor_o ? '0 : lin_addr;
  end

endmodule

// File: rtl/pixel_read_arbiter.sv
// Round-robin arbiter sharing one image RAM read port among NREQ pixel readers.
// Fixed 2-cycle latency, one read per cycle; a 2-stage one-hot tag routes each result home.
module pixel_read_arbiter
  import star_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned X_RES = star_pkg::X_RES,
  parameter int unsigned Y_RES = star_pkg::Y_RES
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req,
  input  logic [COORD_W*NREQ-1:0] reqX,
  input  logic [COORD_W*NREQ-1:0] reqY,
  output logic [NREQ-1:0]         gnt,
  output logic [ADDR_W-1:0]       ramAddr,
  input  logic [PIX_W-1:0]        ramQ,
  output logic [PIX_W-1:0]        pixVal,
  output logic [NREQ-1:0]         pixValid,
  output logic                    oor,
  output logic                    busy
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]    tag1_q, tag1_d;
  logic               oor1_q, oor1_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [NREQ-1:0]    tag2_q, tag2_d;
  logic               oor2_q, oor2_d;

  logic               win_vld;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand_idx;
  logic [COORD_W-1:0] win_x;
  logic [COORD_W-1:0] win_y;
  logic [ADDR_W-1:0]  xl_addr;
  logic               xl_oor;

  // First asserted request at or above the pointer, wrapping modulo NREQ.
  always_comb begin : arbitrate
    win_vld  = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand_idx = PTR_W'((32'(rr_ptr_q) + k) % NREQ);
      if (!win_vld && req[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_comb begin : coord_mux
    win_x = reqX[32'(win_idx) * COORD_W +: COORD_W];
    win_y = reqY[32'(win_idx) * COORD_W +: COORD_W];
  end

  pix_addr_xlate #(
    .X_RES (X_RES),
    .Y_RES (Y_RES)
  ) u_xlate (
    .x_i    (win_x),
    .y_i    (win_y),
    .addr_o (xl_addr),
    .oor_o  (xl_oor)
  );

  always_comb begin : next_state
    rr_ptr_d = rr_ptr_q;
    tag1_d   = '0;
    oor1_d   = 1'b0;
    addr_d   = addr_q;
    tag2_d   = tag1_q;
    oor2_d   = oor1_q;
    if (win_vld) begin
      tag1_d   = NREQ'(1) << win_idx;
      oor1_d   = xl_oor;
      addr_d   = xl_addr;
      rr_ptr_d = PTR_W'(rr_wrap_inc(32'(win_idx), NREQ));
    end
  end

  // Stage boundary: issue (grant + address) -> return (tag aligned with RAM data).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr_q <= PTR_W'(REQ_SCAN);
      tag1_q   <= '0;
      oor1_q   <= 1'b0;
      addr_q   <= '0;
      tag2_q   <= '0;
      oor2_q   <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag1_q   <= tag1_d;
      oor1_q   <= oor1_d;
      addr_q   <= addr_d;
      tag2_q   <= tag2_d;
      oor2_q   <= oor2_d;
    end
  end

  // Out-of-range reads return the black threshold value instead of RAM data.
  assign gnt      = tag1_q;
  assign ramAddr  = addr_q;
  assign pixValid = tag2_q;
  assign oor      = oor2_q;
  assign busy     = (|tag1_q) || (|tag2_q);
  assign pixVal   = ((|tag2_q) && !oor2_q) ? ramQ : PIX_W'(PIX_THRESHOLD);

endmodule

// File: tb/tb_pixel_read_arbiter.sv
// Bench for pixel_read_arbiter: directed scenarios then random traffic, all checked
// against a cycle-level reference model of the round-robin/latency rules.
module tb_pixel_read_arbiter;

  localparam int NREQ = 3;
  localparam int XR   = 60;
  localparam int YR   = 60;

  logic              clk    = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]   req    = '0;
  logic [6*NREQ-1:0] reqX   = '0;
  logic [6*NREQ-1:0] reqY   = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   pixValid;
  logic [11:0]       ramAddr;
  logic [2:0]        ramQ   = '0;
  logic [2:0]        pixVal;
  logic              oor;
  logic              busy;

  logic [2:0] mem [0:4095];

  int n_assert = 0;
  int n_fail   = 0;

  int       m_ptr   = 0;
  bit       m_pend  = 1'b0;
  int       m_owner = 0;
  logic [2:0] m_pix = '0;
  bit       m_oor   = 1'b0;
  int       wait_cnt [NREQ];

  always #5 clk = ~clk;

  always @(posedge clk) ramQ <= mem[ramAddr];

  pixel_read_arbiter #(
    .NREQ  (NREQ),
    .X_RES (XR),
    .Y_RES (YR)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .reqX     (reqX),
    .reqY     (reqY),
    .gnt      (gnt),
    .ramAddr  (ramAddr),
    .ramQ     (ramQ),
    .pixVal   (pixVal),
    .pixValid (pixValid),
    .oor      (oor),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit on, input int x, input int y);
    req[i]          = on;
    reqX[6*i +: 6]  = 6'(x);
    reqY[6*i +: 6]  = 6'(y);
  endtask

  // One clock: predict from the rules, advance, compare every output.
  task automatic step();
    int              win;
    int              c;
    int              x;
    int              y;
    bit              o;
    bit              rst_edge;
    logic [NREQ-1:0] e_gnt;
    logic [NREQ-1:0] e_pv;
    logic [NREQ-1:0] prev_req;
    logic [11:0]     e_addr;
    logic [2:0]      e_pval;
    bit              e_oor;
    win      = -1;
    e_gnt    = '0;
    e_addr   = '0;
    e_pv     = '0;
    e_pval   = '0;
    e_oor    = 1'b0;
    prev_req = req;
    rst_edge = !resetn;
    if (rst_edge) begin
      m_ptr  = 0;
      m_pend = 1'b0;
    end else begin
      if (m_pend) begin
        e_pv   = NREQ'(1) << m_owner;
        e_pval = m_pix;
        e_oor  = m_oor;
      end
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (win < 0 && req[c]) win = c;
      end
      m_pend = (win >= 0);
      if (win >= 0) begin
        x       = int'(reqX[6*win +: 6]);
        y       = int'(reqY[6*win +: 6]);
        o       = (x >= XR) || (y >= YR);
        e_addr  = o ? 12'd0 : 12'(y * XR + x);
        e_gnt   = NREQ'(1) << win;
        m_owner = win;
        m_oor   = o;
        m_pix   = o ? 3'd0 : mem[e_addr];
        m_ptr   = (win + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("pixValid", 32'(pixValid), 32'(e_pv));
    chk("pixVal", 32'(pixVal), 32'(e_pval));
    chk("oor", 32'(oor), 32'(e_oor));
    chk("busy", 32'(busy), 32'((e_gnt != 0) || (e_pv != 0)));
    chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
    chk("pv_onehot", 32'($onehot0(pixValid)), 32'd1);
    if (rst_edge || win >= 0) chk("ramAddr", 32'(ramAddr), 32'(e_addr));
    for (int i = 0; i < NREQ; i++) begin
      if (prev_req[i] && !rst_edge) begin
        wait_cnt[i] = gnt[i] ? 0 : wait_cnt[i] + 1;
        chk("starve", 32'(wait_cnt[i] < NREQ), 32'd1);
      end else begin
        wait_cnt[i] = 0;
      end
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 0, 0);
  endtask

  initial begin
    int exp_seq [6];
    int first_g;
    exp_seq = '{1, 2, 4, 1, 2, 4};
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 3'($urandom_range(0, 7));
    mem[125]  = 3'd7;
    mem[3599] = 3'd6;
    mem[0]    = 3'd5;

    // reset state
    resetn = 1'b0;
    set_req(0, 1'b1, 5, 2);
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(ramAddr), 32'd0);

    // single request
    resetn = 1'b1;
    step();
    chk("single_gnt", 32'(gnt), 32'd1);
    chk("single_addr", 32'(ramAddr), 32'd125);
    clear_reqs();
    step();
    chk("single_pv", 32'(pixValid), 32'd1);
    chk("single_pix", 32'(pixVal), 32'd7);
    chk("single_oor", 32'(oor), 32'd0);
    step();

    // contention from reset
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 1, i + 1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("cont_gnt", 32'(gnt), 32'(exp_seq[k]));
      if (k > 0) chk("cont_pv", 32'(pixValid), 32'(exp_seq[k-1]));
    end
    clear_reqs();
    step();
    step();

    // boundaries
    set_req(0, 1'b1, 59, 59);
    step();
    chk("bnd_addr_max", 32'(ramAddr), 32'd3599);
    set_req(0, 1'b1, 60, 0);
    step();
    chk("bnd_addr_oor", 32'(ramAddr), 32'd0);
    chk("bnd_pix_max", 32'(pixVal), 32'd6);
    clear_reqs();
    step();
    chk("bnd_pix_oor", 32'(pixVal), 32'd0);
    chk("bnd_oor_flag", 32'(oor), 32'd1);
    chk("bnd_pv_oor", 32'(pixValid), 32'd1);
    step();

    // fairness: req[2] held, req[0] toggling
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    set_req(2, 1'b1, 10, 10);
    first_g = -1;
    for (int c = 0; c < 6; c++) begin
      set_req(0, (c % 2) == 0, 4, 4);
      step();
      if (gnt[2] && first_g < 0) first_g = c + 1;
    end
    chk("fair_latency", 32'(first_g >= 1 && first_g <= 3), 32'd1);
    clear_reqs();
    step();
    step();

    // reset mid-flight
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    set_req(0, 1'b1, 1, 1);
    step();
    chk("mid_gnt", 32'(gnt), 32'd1);
    clear_reqs();
    resetn = 1'b0;
    step();
    chk("mid_pv_rst", 32'(pixValid), 32'd0);
    chk("mid_busy_rst", 32'(busy), 32'd0);
    resetn = 1'b1;
    step();
    chk("mid_pv_after", 32'(pixValid), 32'd0);
    chk("mid_busy_after", 32'(busy), 32'd0);
    set_req(0, 1'b1, 2, 2);
    set_req(2, 1'b1, 3, 3);
    step();
    chk("mid_ptr0", 32'(gnt), 32'd1);
    clear_reqs();
    step();
    step();

    // random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      resetn = ($urandom_range(0, 99) != 0);
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1'b1, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        end else if (gnt[i]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(i, 1'b0, 0, 0);
          else
            set_req(i, 1'b1, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        end
      end
    end
    resetn = 1'b1;
    clear_reqs();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
